// File: rtl/cic_pkg.sv
// Shared arithmetic for the CIC integrator and comb sections.
// Values are carried sign-extended in a 64-bit container; only the low `width` bits matter.
package cic_pkg;

    localparam int CIC_MAX_W = 64;

    typedef logic signed [CIC_MAX_W-1:0] wide_t;

    // Largest positive value representable in a signed field of `width` bits.
    function automatic wide_t sat_max(input int width);
        return (wide_t'(1) <<< (width - 1)) - wide_t'(1);
    endfunction

    // Most negative value representable in a signed field of `width` bits.
    function automatic wide_t sat_min(input int width);
        return ~sat_max(width);
    endfunction

    // Returns {ovf, sum}. Overflow is judged on the sign bit of the `width`-bit field,
    // so the low `width` bits of sum are the wrapped result when saturate is 0.
    function automatic logic [CIC_MAX_W:0] sat_add(input wide_t a, input wide_t b,
                                                   input logic saturate, input int width);
        wide_t      sum;
        logic [5:0] msb;
        logic       ovf;
        msb = 6'(width - 1);
        sum = a + b;
        ovf = (a[msb] == b[msb]) && (sum[msb] != a[msb]);
        if (ovf && saturate) begin
            sum = a[msb] ? sat_min(width) : sat_max(width);
        end
        return {ovf, sum};
    endfunction

endpackage

// File: rtl/cic_integrator_stage.sv
// One integrator: accumulator, valid bit and sticky overflow flag.
// Accumulates din_i whenever upd_i is high; clr_i wipes all state on the next edge.
module cic_integrator_stage
    import cic_pkg::*;
#(
    parameter int ACC_WIDTH = 32,
    parameter int SATURATE  = 0
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        clr_i,
    input  logic                        upd_i,
    input  logic signed [ACC_WIDTH-1:0] din_i,
    output logic                        vld_o,
    output logic signed [ACC_WIDTH-1:0] acc_o,
    output logic                        ovf_o
);

    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                        vld_q, vld_d;
    logic                        ovf_q, ovf_d;
    logic [CIC_MAX_W:0]          sum_w;
    logic                        unused_sum;

    assign sum_w      = sat_add(wide_t'(acc_q), wide_t'(din_i), SATURATE != 0, ACC_WIDTH);
    // Bits above ACC_WIDTH are sign copies and carry no information.
    assign unused_sum = ^sum_w;

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        vld_d = upd_i;
        if (clr_i) begin
            acc_d = '0;
            ovf_d = 1'b0;
            vld_d = 1'b0;
        end else if (upd_i) begin
            acc_d = sum_w[ACC_WIDTH-1:0];
            ovf_d = ovf_q | sum_w[CIC_MAX_W];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q <= '0;
            vld_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            vld_q <= vld_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc_o = acc_q;
    assign vld_o = vld_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/cic_integrator_chain.sv
// Cascade of STAGES integrators feeding the CIC decimation/comb section.
// Each stage updates only when the stage before it produced a valid sample.
module cic_integrator_chain
    import cic_pkg::*;
#(
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = 32,
    parameter int STAGES    = 3,
    parameter int SATURATE  = 0
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        clr,
    input  logic                        in_valid,
    input  logic signed [IN_WIDTH-1:0]  x,
    output logic                        out_valid,
    output logic signed [ACC_WIDTH-1:0] y,
    output logic [STAGES-1:0]           ovf
);

    if (ACC_WIDTH < IN_WIDTH) begin : g_chk_width
        $error("cic_integrator_chain: ACC_WIDTH must be >= IN_WIDTH");
    end
    if (ACC_WIDTH > CIC_MAX_W) begin : g_chk_max
        $error("cic_integrator_chain: ACC_WIDTH exceeds cic_pkg::CIC_MAX_W");
    end
    if (STAGES < 1 || STAGES > 8) begin : g_chk_stages
        $error("cic_integrator_chain: STAGES must be in 1..8");
    end

    logic signed [ACC_WIDTH-1:0] x_ext;
    logic signed [ACC_WIDTH-1:0] acc_w [STAGES];
    logic [STAGES-1:0]           vld_w;

    assign x_ext = ACC_WIDTH'(x);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic                        upd_w;
        logic signed [ACC_WIDTH-1:0] din_w;

        if (k == 0) begin : g_first
            assign upd_w = in_valid;
            assign din_w = x_ext;
        end else begin : g_next
            assign upd_w = vld_w[k-1];
            assign din_w = acc_w[k-1];
        end

        cic_integrator_stage #(
            .ACC_WIDTH (ACC_WIDTH),
            .SATURATE  (SATURATE)
        ) u_stage (
            .clk   (clk),
            .rstn  (rstn),
            .clr_i (clr),
            .upd_i (upd_w),
            .din_i (din_w),
            .vld_o (vld_w[k]),
            .acc_o (acc_w[k]),
            .ovf_o (ovf[k])
        );
    end

    assign y         = acc_w[STAGES-1];
    assign out_valid = vld_w[STAGES-1];

endmodule

// File: doc/cic_integrator_chain.md
# cic_integrator_chain

Parametrised cascade of N integrator stages for the CIC decimator front end. Each stage computes a(n) = x(n) + a(n-1) on valid samples only. The block adds a valid qualifier, selectable wrap/saturate arithmetic, per-stage sticky overflow flags and a synchronous clear. It sits between the input sample source and the decimation/comb section, and replaces the single-stage integrator in new filter builds.

## Interface
Parameters:
- IN_WIDTH, 8, input sample width, signed two's complement
- ACC_WIDTH, 32, accumulator width of every stage; must be >= IN_WIDTH (elaboration error otherwise)
- STAGES, 3, number of cascaded integrators, 1..8
- SATURATE, 0: 0 = modular wrap (CIC-correct), 1 = clamp to signed min/max

Ports:
- clk  input  1  clock; all state updates on its rising edge
- rstn  input  1  asynchronous active-low reset
- clr  input  1  synchronous clear of all state
- in_valid  input  1  x is a valid sample this cycle
- x  input  IN_WIDTH  signed input sample
- out_valid  output  1  y is valid this cycle
- y  output  ACC_WIDTH  signed output of the last stage
- ovf  output  STAGES  sticky overflow flag per stage; bit k belongs to stage k

## Operation
- Stage 0 input: x sign-extended to ACC_WIDTH. Stage k input (k>0): acc[k-1].
- Stage k has a valid bit v[k]. Stage 0 update condition: in_valid. Stage k update condition: v[k-1].
- On its update condition, stage k loads the sum: acc[k] <= acc[k] + in_k. v[k] <= update condition in every cycle.
- Sum is formed at ACC_WIDTH+1 bits. Signed overflow means the operands have the same sign and the result sign differs.
- Overflow with SATURATE=0: store the low ACC_WIDTH bits (wrap).
- Overflow with SATURATE=1: store 2^(ACC_WIDTH-1)-1 if the operands were positive, -2^(ACC_WIDTH-1) if negative.
- ovf[k] is set on any overflow in stage k, in either mode. It stays set until clr or reset.
- y = acc[STAGES-1]; out_valid = v[STAGES-1].
- clr: all acc, v and ovf go to 0 on the next edge.
- clr beats in_valid: a sample presented in the clr cycle is dropped. Samples already in flight are discarded.
- Gaps in in_valid freeze all accumulators. Accumulator state is preserved across gaps.

## Timing
- Reset (rstn low, asynchronous): acc = 0, v = 0, ovf = 0. Outputs y = 0, out_valid = 0, ovf = 0 immediately.
- Reset asserted mid-stream discards all state. First valid after release behaves as after power-up.
- Latency: a sample with in_valid high in cycle t gives its contribution on y with out_valid high in cycle t+STAGES.
- Throughput: one sample per cycle, no backpressure. The downstream block must accept every out_valid.
- y holds its last value while out_valid is low.
- ovf[k] is visible the cycle after the overflowing update.

## Structure
- Shared package cic_pkg holds:
  - function sat_add(a, b, saturate) returning {ovf, sum}, reused by the comb stages
  - localparams for the signed max/min of ACC_WIDTH
- Sub-module cic_integrator_stage (one accumulator + valid bit + sticky flag), instantiated STAGES times in a generate loop.
- Top level contains only sign extension, stage chaining and output mapping.

## Test plan
- Impulse, IN_WIDTH=8, ACC_WIDTH=12, STAGES=3: x=1 for one valid cycle, then x=0 valid.
  - First out_valid 3 cycles after the impulse.
  - y = 1, 3, 6, 10, 15; ovf = 0.
- Step, same config: x=1 every cycle.
  - y = 1, 4, 10, 20, 35.
  - With in_valid toggling 1/0, the same sequence appears only on out_valid cycles, and y holds between them.
- Wrap, STAGES=1, ACC_WIDTH=12, SATURATE=0: x=127 continuously.
  - 16th output = 2032.
  - 17th output = -1937.
  - ovf[0] set on the cycle after the 17th update and stays set.
- Saturate, same stimulus with SATURATE=1:
  - 17th and later outputs = 2047.
  - ovf[0] = 1.
  - Same with x=-128: clamps to -2048.
- clr and reset: after a running step sequence, assert clr together with in_valid=1.
  - Next cycle: y = 0, out_valid = 0, ovf = 0.
  - Subsequent step restarts at 1, 4, 10.
  - Repeat with rstn pulsed low mid-stream, asynchronous to clk: outputs are 0 while rstn is low.
